ycbcr_skin_locator: RTL and testbench
=====================================

Name: ycbcr_skin_locator

Overview:
- Parametrised successor to the fixed-threshold YCbCr skin-colour locator in the image IP hub.
- Classifies each pixel against run-time programmable Y/Cb/Cr windows and emits one selectable output stream: binary, masked RGB, masked gray, or RGB with a bounding-box overlay.
- Accumulates a per-frame bounding box and pixel count of matching pixels, published at the start of each frame's vsync.
- Sits after the RGB-to-YCbCr converter; its box outputs feed downstream tracking/OSD.

Parameters:
- CH_WIDTH, 8, bits per colour channel; pixel buses are 3*CH_WIDTH.
- X_BITS, 12, width of column counter and box X outputs.
- Y_BITS, 12, width of row counter and box Y outputs.
- CNT_BITS, 22, width of the match-pixel counter (saturating).
- MIN_PIXELS, 64, minimum matches per frame for box_found=1.
- BOX_COLOR, 24'h00FF00, overlay colour (3*CH_WIDTH bits).
- DEF_Y_LOW/DEF_Y_HIGH/DEF_CB_LOW/DEF_CB_HIGH/DEF_CR_LOW/DEF_CR_HIGH, 0/255/123/165/110/132, reset values of the shadow thresholds.

Ports:
- pixelclk  in  1  pixel clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- cfg_y_low, cfg_y_high, cfg_cb_low, cfg_cb_high, cfg_cr_low, cfg_cr_high  in  CH_WIDTH each  threshold requests.
- cfg_mode  in  2  0=binary, 1=masked RGB, 2=masked gray, 3=RGB+box overlay.
- i_rgb, i_gray, i_ycbcr  in  3*CH_WIDTH  pixel data; i_ycbcr packed Y[MSB], Cb, Cr[LSB].
- i_hsync, i_vsync, i_de  in  1  video timing, active-high.
- o_pixel  out  3*CH_WIDTH  selected output pixel.
- o_hsync, o_vsync, o_de  out  1  timing delayed to match o_pixel.
- box_x_min, box_x_max  out  X_BITS  latched box columns.
- box_y_min, box_y_max  out  Y_BITS  latched box rows.
- box_count  out  CNT_BITS  latched match count.
- box_found  out  1  latched box is valid.
- frame_done  out  1  one-cycle pulse when box outputs update.

Behaviour:
- Reset (synchronous, active-high): every output is 0, all counters and accumulators are cleared, and the shadow thresholds and mode take their DEF_* values (mode 0).
- vs_rise: i_vsync=1 while the previous-cycle i_vsync=0.
- Shadow config: the cfg_* thresholds and cfg_mode are sampled into shadow registers on vs_rise only. Mid-frame cfg changes have no effect until the next frame.
- Match: Y, Cb and Cr are each inside their window, inclusive: low <= v <= high. A window with low > high never matches.
- Pipeline: two register stages.
  - Stage 1 registers the match flag, the pixel data, and x/y.
  - Stage 2 registers o_pixel.
  - o_pixel, o_hsync, o_vsync and o_de all have a latency of exactly 2 cycles.
- Output select (at stage 2):
  - Mode 0: match -> 0, else all-ones.
  - Mode 1: match -> rgb, else all-ones.
  - Mode 2: match -> gray, else all-ones.
  - Mode 3: rgb, replaced by BOX_COLOR on the border of the currently latched box when box_found=1. The border is x in {x_min, x_max} with y_min<=y<=y_max, or y in {y_min, y_max} with x_min<=x<=x_max.
  - The output value is don't-care-free: it is driven even when de=0, but the bench checks only de=1 cycles.
- Counters:
  - x increments on each i_de=1 cycle and clears on the i_de falling edge.
  - y increments on the i_de falling edge.
  - Both clear on vs_rise.
  - Both saturate at their all-ones value (no wrap).
- Accumulator: for each i_de=1 match, update x_min/x_max/y_min/y_max and increment cnt. cnt saturates at all-ones.
- Publish on vs_rise:
  - box_* <= accumulator values; box_count <= cnt.
  - box_found <= (cnt >= MIN_PIXELS) AND frame_valid.
  - frame_done=1 in the following cycle only.
  - Accumulators re-initialise: min = all-ones, max = 0, cnt = 0.
  - If box_found would be 0, box_x/y_* are published as 0.
- Simultaneous events: if a matching de=1 pixel coincides with vs_rise, it belongs to the new frame and is accumulated after the clear.
- frame_valid: cleared by reset, set on the first vs_rise after reset. The partial frame after reset is therefore never published as found; frame_done still pulses.
- Reset mid-frame aborts accumulation. Outputs stay 0 until data propagates through the pipeline.

Decomposition:
- Package ycbcr_pkg holds the mode encodings (MODE_BINARY=0, MODE_RGB=1, MODE_GRAY=2, MODE_OVERLAY=3) and the channel-packing offsets.
- One sub-module, ycbcr_bbox_acc, contains the x/y counters, min/max/count accumulation, frame_valid, and the publish/frame_done logic.
- The top level contains the shadow registers, comparators, pipeline, and output mux.

Test Plan:
- Reset with defaults, then a 4x4 frame of ycbcr=0x80_90_78 in mode 0 -> every de pixel gives o_pixel=0, with latency 2 cycles on pixel and syncs.
- Mode 1 with Cb=0xA6 (above 165) on odd columns -> those pixels give 0xFFFFFF and the others pass i_rgb. Repeat with Cb=165 exactly -> match (inclusive).
- 16x16 frames, matches only in a block at x 3..10, y 5..12 (64 px), then vs_rise -> frame_done pulse, box=(3,10,5,12), box_count=64, box_found=1. Repeat with 63 px -> box_found=0, box coordinates 0.
- cfg_cr_high changed mid-frame -> the current frame's classification is unchanged; the change takes effect after the next vs_rise.
- Mode 3 with the previous frame's box (3,10,5,12) -> border pixels equal 0x00FF00, interior pixels equal i_rgb.
- Reset asserted mid-frame, then the remainder of the frame, then vs_rise -> frame_done pulses with box_found=0. The next full frame publishes normally.

Source files
------------

// File: rtl/ycbcr_pkg.sv
// Shared definitions for the YCbCr skin locator.
// Holds the output-mode encodings and channel positions inside packed pixel buses.
package ycbcr_pkg;

    typedef enum logic [1:0] {
        MODE_BINARY  = 2'd0,
        MODE_RGB     = 2'd1,
        MODE_GRAY    = 2'd2,
        MODE_OVERLAY = 2'd3
    } mode_e;

    // Channel index within a packed Y/Cb/Cr bus (index 0 = LSB channel)
    localparam int Y_CH  = 2;
    localparam int CB_CH = 1;
    localparam int CR_CH = 0;

endpackage

// File: rtl/ycbcr_bbox_acc.sv
// Column/row counters plus per-frame bounding-box and match-count accumulation.
// Ports: clk_i/reset_i, vs_rise_i/de_i/match_i in; pix_x_o/pix_y_o (current
// pixel coordinate), latched box_*_o, box_found_o and frame_done_o out.
module ycbcr_bbox_acc
#(
    parameter int X_BITS     = 12,
    parameter int Y_BITS     = 12,
    parameter int CNT_BITS   = 22,
    parameter int MIN_PIXELS = 64
)
(
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                vs_rise_i,
    input  logic                de_i,
    input  logic                match_i,
    output logic [X_BITS-1:0]   pix_x_o,
    output logic [Y_BITS-1:0]   pix_y_o,
    output logic [X_BITS-1:0]   box_x_min_o,
    output logic [X_BITS-1:0]   box_x_max_o,
    output logic [Y_BITS-1:0]   box_y_min_o,
    output logic [Y_BITS-1:0]   box_y_max_o,
    output logic [CNT_BITS-1:0] box_count_o,
    output logic                box_found_o,
    output logic                frame_done_o
);

    logic                de_prev_q, de_fall;
    logic [X_BITS-1:0]   x_q, x_d, x_base;
    logic [Y_BITS-1:0]   y_q, y_d, y_base;
    logic [X_BITS-1:0]   xmin_q, xmin_d, xmin_b, xmax_q, xmax_d, xmax_b;
    logic [Y_BITS-1:0]   ymin_q, ymin_d, ymin_b, ymax_q, ymax_d, ymax_b;
    logic [CNT_BITS-1:0] cnt_q, cnt_d, cnt_b;
    logic                fv_q, found_d;

    // A pixel coinciding with vs_rise is the first pixel of the new frame,
    // so everything is computed from the cleared values in that cycle.
    always_comb begin
        de_fall = de_prev_q & ~de_i;
        x_base  = vs_rise_i ? '0 : x_q;
        y_base  = vs_rise_i ? '0 : y_q;
        pix_x_o = x_base;
        pix_y_o = y_base;

        x_d = x_base;
        if (de_i) begin
            if (x_base != '1) x_d = x_base + X_BITS'(1);
        end else if (de_fall) begin
            x_d = '0;
        end

        y_d = y_base;
        if (de_fall && !vs_rise_i && y_q != '1) y_d = y_q + Y_BITS'(1);

        xmin_b = vs_rise_i ? '1 : xmin_q;
        xmax_b = vs_rise_i ? '0 : xmax_q;
        ymin_b = vs_rise_i ? '1 : ymin_q;
        ymax_b = vs_rise_i ? '0 : ymax_q;
        cnt_b  = vs_rise_i ? '0 : cnt_q;

        xmin_d = xmin_b;
        xmax_d = xmax_b;
        ymin_d = ymin_b;
        ymax_d = ymax_b;
        cnt_d  = cnt_b;
        if (de_i && match_i) begin
            if (x_base < xmin_b) xmin_d = x_base;
            if (x_base > xmax_b) xmax_d = x_base;
            if (y_base < ymin_b) ymin_d = y_base;
            if (y_base > ymax_b) ymax_d = y_base;
            if (cnt_b != '1) cnt_d = cnt_b + CNT_BITS'(1);
        end

        // The frame before the first vsync after reset is partial
        found_d = fv_q && (cnt_q >= CNT_BITS'(MIN_PIXELS));
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            de_prev_q    <= 1'b0;
            x_q          <= '0;
            y_q          <= '0;
            xmin_q       <= '1;
            xmax_q       <= '0;
            ymin_q       <= '1;
            ymax_q       <= '0;
            cnt_q        <= '0;
            fv_q         <= 1'b0;
            box_x_min_o  <= '0;
            box_x_max_o  <= '0;
            box_y_min_o  <= '0;
            box_y_max_o  <= '0;
            box_count_o  <= '0;
            box_found_o  <= 1'b0;
            frame_done_o <= 1'b0;
        end else begin
            de_prev_q    <= de_i;
            x_q          <= x_d;
            y_q          <= y_d;
            xmin_q       <= xmin_d;
            xmax_q       <= xmax_d;
            ymin_q       <= ymin_d;
            ymax_q       <= ymax_d;
            cnt_q        <= cnt_d;
            fv_q         <= fv_q | vs_rise_i;
            frame_done_o <= vs_rise_i;
            if (vs_rise_i) begin
                box_x_min_o <= found_d ? xmin_q : '0;
                box_x_max_o <= found_d ? xmax_q : '0;
                box_y_min_o <= found_d ? ymin_q : '0;
                box_y_max_o <= found_d ? ymax_q : '0;
                box_count_o <= cnt_q;
                box_found_o <= found_d;
            end
        end
    end

endmodule

// File: rtl/ycbcr_skin_locator.sv
// YCbCr skin-colour locator with frame-latched thresholds and a selectable output.
// Ports: pixelclk/reset, cfg_* thresholds and mode, i_* pixel and timing in;
// o_* pixel and timing (2-cycle latency), latched box_*, box_found, frame_done out.
module ycbcr_skin_locator
    import ycbcr_pkg::*;
#(
    parameter int                      CH_WIDTH    = 8,
    parameter int                      X_BITS      = 12,
    parameter int                      Y_BITS      = 12,
    parameter int                      CNT_BITS    = 22,
    parameter int                      MIN_PIXELS  = 64,
    parameter logic [3*CH_WIDTH-1:0]   BOX_COLOR   = 24'h00FF00,
    parameter int                      DEF_Y_LOW   = 0,
    parameter int                      DEF_Y_HIGH  = 255,
    parameter int                      DEF_CB_LOW  = 123,
    parameter int                      DEF_CB_HIGH = 165,
    parameter int                      DEF_CR_LOW  = 110,
    parameter int                      DEF_CR_HIGH = 132
)
(
    input  logic                  pixelclk,
    input  logic                  reset,
    input  logic [CH_WIDTH-1:0]   cfg_y_low,
    input  logic [CH_WIDTH-1:0]   cfg_y_high,
    input  logic [CH_WIDTH-1:0]   cfg_cb_low,
    input  logic [CH_WIDTH-1:0]   cfg_cb_high,
    input  logic [CH_WIDTH-1:0]   cfg_cr_low,
    input  logic [CH_WIDTH-1:0]   cfg_cr_high,
    input  logic [1:0]            cfg_mode,
    input  logic [3*CH_WIDTH-1:0] i_rgb,
    input  logic [3*CH_WIDTH-1:0] i_gray,
    input  logic [3*CH_WIDTH-1:0] i_ycbcr,
    input  logic                  i_hsync,
    input  logic                  i_vsync,
    input  logic                  i_de,
    output logic [3*CH_WIDTH-1:0] o_pixel,
    output logic                  o_hsync,
    output logic                  o_vsync,
    output logic                  o_de,
    output logic [X_BITS-1:0]     box_x_min,
    output logic [X_BITS-1:0]     box_x_max,
    output logic [Y_BITS-1:0]     box_y_min,
    output logic [Y_BITS-1:0]     box_y_max,
    output logic [CNT_BITS-1:0]   box_count,
    output logic                  box_found,
    output logic                  frame_done
);

    localparam int PW = 3*CH_WIDTH;
    typedef logic [CH_WIDTH-1:0] ch_t;

    logic  vs_prev_q, vs_rise, match;
    ch_t   ylo_q, yhi_q, cblo_q, cbhi_q, crlo_q, crhi_q;
    ch_t   ylo, yhi, cblo, cbhi, crlo, crhi;
    ch_t   y_v, cb_v, cr_v;
    mode_e mode_q;

    logic              s1_match_q, s1_hs_q, s1_vs_q, s1_de_q;
    logic [PW-1:0]     s1_rgb_q, s1_gray_q, pix_d;
    logic [X_BITS-1:0] s1_x_q, pix_x;
    logic [Y_BITS-1:0] s1_y_q, pix_y;
    logic              in_x, in_y, on_border;

    function automatic logic in_win(ch_t v, ch_t lo, ch_t hi);
        return (v >= lo) && (v <= hi);
    endfunction

    assign vs_rise = i_vsync & ~vs_prev_q;

    // The pixel on the vs_rise cycle belongs to the new frame, so it is
    // classified with the thresholds being sampled in that same cycle.
    assign ylo  = vs_rise ? cfg_y_low   : ylo_q;
    assign yhi  = vs_rise ? cfg_y_high  : yhi_q;
    assign cblo = vs_rise ? cfg_cb_low  : cblo_q;
    assign cbhi = vs_rise ? cfg_cb_high : cbhi_q;
    assign crlo = vs_rise ? cfg_cr_low  : crlo_q;
    assign crhi = vs_rise ? cfg_cr_high : crhi_q;

    assign y_v  = i_ycbcr[Y_CH*CH_WIDTH  +: CH_WIDTH];
    assign cb_v = i_ycbcr[CB_CH*CH_WIDTH +: CH_WIDTH];
    assign cr_v = i_ycbcr[CR_CH*CH_WIDTH +: CH_WIDTH];

    assign match = in_win(y_v, ylo, yhi)
                 & in_win(cb_v, cblo, cbhi)
                 & in_win(cr_v, crlo, crhi);

    ycbcr_bbox_acc #(
        .X_BITS     (X_BITS),
        .Y_BITS     (Y_BITS),
        .CNT_BITS   (CNT_BITS),
        .MIN_PIXELS (MIN_PIXELS)
    ) u_acc (
        .clk_i        (pixelclk),
        .reset_i      (reset),
        .vs_rise_i    (vs_rise),
        .de_i         (i_de),
        .match_i      (match),
        .pix_x_o      (pix_x),
        .pix_y_o      (pix_y),
        .box_x_min_o  (box_x_min),
        .box_x_max_o  (box_x_max),
        .box_y_min_o  (box_y_min),
        .box_y_max_o  (box_y_max),
        .box_count_o  (box_count),
        .box_found_o  (box_found),
        .frame_done_o (frame_done)
    );

    always_comb begin
        in_x = (s1_x_q >= box_x_min) && (s1_x_q <= box_x_max);
        in_y = (s1_y_q >= box_y_min) && (s1_y_q <= box_y_max);
        on_border = box_found &&
            ((((s1_x_q == box_x_min) || (s1_x_q == box_x_max)) && in_y) ||
             (((s1_y_q == box_y_min) || (s1_y_q == box_y_max)) && in_x));
        pix_d = '1;
        unique case (mode_q)
            MODE_BINARY:  if (s1_match_q) pix_d = '0;
            MODE_RGB:     if (s1_match_q) pix_d = s1_rgb_q;
            MODE_GRAY:    if (s1_match_q) pix_d = s1_gray_q;
            MODE_OVERLAY: pix_d = on_border ? BOX_COLOR : s1_rgb_q;
            default:      pix_d = '1;
        endcase
    end

    always_ff @(posedge pixelclk) begin
        if (reset) begin
            vs_prev_q  <= 1'b0;
            ylo_q      <= CH_WIDTH'(DEF_Y_LOW);
            yhi_q      <= CH_WIDTH'(DEF_Y_HIGH);
            cblo_q     <= CH_WIDTH'(DEF_CB_LOW);
            cbhi_q     <= CH_WIDTH'(DEF_CB_HIGH);
            crlo_q     <= CH_WIDTH'(DEF_CR_LOW);
            crhi_q     <= CH_WIDTH'(DEF_CR_HIGH);
            mode_q     <= MODE_BINARY;
            s1_match_q <= 1'b0;
            s1_rgb_q   <= '0;
            s1_gray_q  <= '0;
            s1_x_q     <= '0;
            s1_y_q     <= '0;
            s1_hs_q    <= 1'b0;
            s1_vs_q    <= 1'b0;
            s1_de_q    <= 1'b0;
            o_pixel    <= '0;
            o_hsync    <= 1'b0;
            o_vsync    <= 1'b0;
            o_de       <= 1'b0;
        end else begin
            vs_prev_q <= i_vsync;
            if (vs_rise) begin
                ylo_q  <= cfg_y_low;
                yhi_q  <= cfg_y_high;
                cblo_q <= cfg_cb_low;
                cbhi_q <= cfg_cb_high;
                crlo_q <= cfg_cr_low;
                crhi_q <= cfg_cr_high;
                mode_q <= mode_e'(cfg_mode);
            end
            s1_match_q <= match;
            s1_rgb_q   <= i_rgb;
            s1_gray_q  <= i_gray;
            s1_x_q     <= pix_x;
            s1_y_q     <= pix_y;
            s1_hs_q    <= i_hsync;
            s1_vs_q    <= i_vsync;
            s1_de_q    <= i_de;
            o_pixel    <= pix_d;
            o_hsync    <= s1_hs_q;
            o_vsync    <= s1_vs_q;
            o_de       <= s1_de_q;
        end
    end

endmodule

// File: tb/tb_ycbcr_skin_locator.sv
// Self-checking bench for ycbcr_skin_locator: table of frames with expected
// publish results, per-pixel output model, and a mid-frame reset sequence.
module tb_ycbcr_skin_locator;

    logic        pixelclk = 1'b0;
    logic        reset;
    logic [7:0]  cfg_y_low, cfg_y_high, cfg_cb_low, cfg_cb_high;
    logic [7:0]  cfg_cr_low, cfg_cr_high;
    logic [1:0]  cfg_mode;
    logic [23:0] i_rgb, i_gray, i_ycbcr;
    logic        i_hsync, i_vsync, i_de;
    logic [23:0] o_pixel;
    logic        o_hsync, o_vsync, o_de;
    logic [11:0] box_x_min, box_x_max, box_y_min, box_y_max;
    logic [21:0] box_count;
    logic        box_found, frame_done;

    always #5 pixelclk = ~pixelclk;

    ycbcr_skin_locator dut (
        .pixelclk    (pixelclk),
        .reset       (reset),
        .cfg_y_low   (cfg_y_low),
        .cfg_y_high  (cfg_y_high),
        .cfg_cb_low  (cfg_cb_low),
        .cfg_cb_high (cfg_cb_high),
        .cfg_cr_low  (cfg_cr_low),
        .cfg_cr_high (cfg_cr_high),
        .cfg_mode    (cfg_mode),
        .i_rgb       (i_rgb),
        .i_gray      (i_gray),
        .i_ycbcr     (i_ycbcr),
        .i_hsync     (i_hsync),
        .i_vsync     (i_vsync),
        .i_de        (i_de),
        .o_pixel     (o_pixel),
        .o_hsync     (o_hsync),
        .o_vsync     (o_vsync),
        .o_de        (o_de),
        .box_x_min   (box_x_min),
        .box_x_max   (box_x_max),
        .box_y_min   (box_y_min),
        .box_y_max   (box_y_max),
        .box_count   (box_count),
        .box_found   (box_found),
        .frame_done  (frame_done)
    );

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        de;
        logic [23:0] pix;
    } pe_t;

    // One frame: geometry, pattern, mode, optional mid-frame reset row,
    // optional mid-frame cr_high write, and the publish expected at its vsync.
    typedef struct {
        int w; int h; int pat; int mode; int rst_row; int cfg_row; int cr;
        int xmin; int xmax; int ymin; int ymax; int cnt; int found;
    } vec_t;

    vec_t vecs[12];
    pe_t  e1, e2;
    int   n_chk = 0;
    int   n_fail = 0;

    logic [7:0] mt_ylo, mt_yhi, mt_cblo, mt_cbhi, mt_crlo, mt_crhi;
    int         m_mode;
    int         eb_xmin, eb_xmax, eb_ymin, eb_ymax;
    int         eb_found;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [23:0] gen_ycc(int pat, int x, int y);
        logic blk;
        blk = (x >= 3) && (x <= 10) && (y >= 5) && (y <= 12);
        case (pat)
            0: return 24'h809078;
            1: return (x % 2 == 1) ? 24'h80A678 : 24'h809078;
            2: return (x % 2 == 1) ? 24'h80A578 : 24'h809078;
            3: return blk ? 24'h809078 : 24'h801078;
            4: return (blk && !(x == 10 && y == 12)) ? 24'h809078 : 24'h801078;
            default: return 24'h809080;
        endcase
    endfunction

    function automatic logic [23:0] exp_pix(logic [23:0] ycc, logic [23:0] rgb,
                                            logic [23:0] gray, int x, int y);
        logic m, bx;
        m = ycc[23:16] >= mt_ylo  && ycc[23:16] <= mt_yhi &&
            ycc[15:8]  >= mt_cblo && ycc[15:8]  <= mt_cbhi &&
            ycc[7:0]   >= mt_crlo && ycc[7:0]   <= mt_crhi;
        bx = (eb_found != 0) &&
             (((x == eb_xmin || x == eb_xmax) && y >= eb_ymin && y <= eb_ymax) ||
              ((y == eb_ymin || y == eb_ymax) && x >= eb_xmin && x <= eb_xmax));
        case (m_mode)
            0: return m ? 24'h000000 : 24'hFFFFFF;
            1: return m ? rgb : 24'hFFFFFF;
            2: return m ? gray : 24'hFFFFFF;
            default: return bx ? 24'h00FF00 : rgb;
        endcase
    endfunction

    task automatic cyc(input logic hs, input logic vs, input logic de,
                       input int x, input int y, input int pat);
        pe_t cur;
        i_hsync = hs;
        i_vsync = vs;
        i_de    = de;
        i_rgb   = {8'(x), 8'(y), 8'h3C};
        i_gray  = {3{8'(x + y)}};
        i_ycbcr = gen_ycc(pat, x, y);
        cur.hs  = hs;
        cur.vs  = vs;
        cur.de  = de;
        cur.pix = exp_pix(i_ycbcr, i_rgb, i_gray, x, y);
        @(posedge pixelclk);
        #1;
        e2 = e1;
        e1 = cur;
        chk("sync", {29'd0, o_hsync, o_vsync, o_de}, {29'd0, e2.hs, e2.vs, e2.de});
        if (e2.de) chk("pixel", {8'd0, o_pixel}, {8'd0, e2.pix});
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        i_hsync = 1'b0;
        i_vsync = 1'b0;
        i_de    = 1'b0;
        @(posedge pixelclk);
        #1;
        chk("rst_pixel", {8'd0, o_pixel}, 32'd0);
        chk("rst_sync", {29'd0, o_hsync, o_vsync, o_de}, 32'd0);
        chk("rst_box_x", {8'd0, box_x_min, box_x_max}, 32'd0);
        chk("rst_box_y", {8'd0, box_y_min, box_y_max}, 32'd0);
        chk("rst_count", {10'd0, box_count}, 32'd0);
        chk("rst_flags", {30'd0, box_found, frame_done}, 32'd0);
        reset   = 1'b0;
        e1      = '0;
        e2      = '0;
        mt_ylo  = 8'd0;
        mt_yhi  = 8'd255;
        mt_cblo = 8'd123;
        mt_cbhi = 8'd165;
        mt_crlo = 8'd110;
        mt_crhi = 8'd132;
        m_mode  = 0;
        eb_xmin = 0; eb_xmax = 0; eb_ymin = 0; eb_ymax = 0;
        eb_found = 0;
    endtask

    task automatic run_frame(input vec_t v);
        cfg_mode = 2'(v.mode);
        mt_ylo  = cfg_y_low;
        mt_yhi  = cfg_y_high;
        mt_cblo = cfg_cb_low;
        mt_cbhi = cfg_cb_high;
        mt_crlo = cfg_cr_low;
        mt_crhi = cfg_cr_high;
        m_mode  = v.mode;
        cyc(1'b0, 1'b1, 1'b0, 0, 0, 0);
        chk("frame_done_pulse", {31'd0, frame_done}, 32'd1);
        chk("box_x_min", {20'd0, box_x_min}, v.xmin);
        chk("box_x_max", {20'd0, box_x_max}, v.xmax);
        chk("box_y_min", {20'd0, box_y_min}, v.ymin);
        chk("box_y_max", {20'd0, box_y_max}, v.ymax);
        chk("box_count", {10'd0, box_count}, v.cnt);
        chk("box_found", {31'd0, box_found}, v.found);
        eb_xmin = v.xmin; eb_xmax = v.xmax;
        eb_ymin = v.ymin; eb_ymax = v.ymax;
        eb_found = v.found;
        cyc(1'b0, 1'b1, 1'b0, 0, 0, 0);
        chk("frame_done_single", {31'd0, frame_done}, 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 0, 0, 0);
        cyc(1'b0, 1'b0, 1'b0, 0, 0, 0);
        for (int y = 0; y < v.h; y++) begin
            if (y == v.rst_row) do_reset();
            if (y == v.cfg_row) cfg_cr_high = 8'(v.cr);
            for (int x = 0; x < v.w; x++) cyc(1'b0, 1'b0, 1'b1, x, y, v.pat);
            cyc(1'b1, 1'b0, 1'b0, 0, 0, 0);
            cyc(1'b0, 1'b0, 1'b0, 0, 0, 0);
        end
    endtask

    initial begin
        //          w   h pat md rst cfg  cr  xmn xmx ymn ymx cnt fnd
        vecs[0]  = '{ 4,  4, 0, 0, -1, -1,   0,  0,  0,  0,  0,   0, 0};
        vecs[1]  = '{ 4,  4, 1, 1, -1, -1,   0,  0,  0,  0,  0,  16, 0};
        vecs[2]  = '{ 4,  4, 2, 1, -1, -1,   0,  0,  0,  0,  0,   8, 0};
        vecs[3]  = '{16, 16, 4, 1, -1, -1,   0,  0,  0,  0,  0,  16, 0};
        vecs[4]  = '{16, 16, 3, 2, -1, -1,   0,  0,  0,  0,  0,  63, 0};
        vecs[5]  = '{16, 16, 3, 3, -1, -1,   0,  3, 10,  5, 12,  64, 1};
        vecs[6]  = '{16, 16, 5, 1, -1,  4, 127,  3, 10,  5, 12,  64, 1};
        vecs[7]  = '{16, 16, 5, 1, -1,  2, 132,  0, 15,  0, 15, 256, 1};
        vecs[8]  = '{16, 16, 3, 1,  8, -1,   0,  0,  0,  0,  0,   0, 0};
        vecs[9]  = '{16, 16, 3, 1, -1, -1,   0,  0,  0,  0,  0,  40, 0};
        vecs[10] = '{ 4,  4, 0, 0, -1, -1,   0,  3, 10,  5, 12,  64, 1};
        vecs[11] = '{ 4,  0, 0, 0, -1, -1,   0,  0,  0,  0,  0,  16, 0};

        cfg_y_low   = 8'd0;
        cfg_y_high  = 8'd255;
        cfg_cb_low  = 8'd123;
        cfg_cb_high = 8'd165;
        cfg_cr_low  = 8'd110;
        cfg_cr_high = 8'd132;
        cfg_mode    = 2'd0;
        i_rgb = '0; i_gray = '0; i_ycbcr = '0;
        i_hsync = 1'b0; i_vsync = 1'b0; i_de = 1'b0;
        e1 = '0;
        e2 = '0;
        reset = 1'b1;
        repeat (2) @(posedge pixelclk);
        #1;
        do_reset();
        repeat (3) cyc(1'b0, 1'b0, 1'b0, 0, 0, 0);

        for (int i = 0; i < 12; i++) run_frame(vecs[i]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
